// File: rtl/borrow_select_subtractor_seq_pkg.sv
// sub_pkg: FSM state type and index-width helper for borrow_select_subtractor_seq.
package sub_pkg;
   typedef enum logic [1:0] {IDLE, CALC, DONE} sub_state_t;
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/borrow_select_subtractor_seq_chunk.sv
// sub_chunk: W-bit borrow-select slice, both borrow-in cases computed and muxed by bin.
module sub_chunk #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bin,
   output logic [W-1:0] d,
   output logic         bout
);
   logic [W:0]   br0, br1;
   logic [W-1:0] d0, d1;
   always_comb begin
      br0[0] = 1'b0;
      br1[0] = 1'b1;
      for (int i = 0; i < W; i++) begin
         d0[i]     = a[i] ^ b[i] ^ br0[i];
         d1[i]     = a[i] ^ b[i] ^ br1[i];
         br0[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br0[i]);
         br1[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br1[i]);
      end
   end
   assign d    = bin ? d1 : d0;
   assign bout = bin ? br1[W] : br0[W];
endmodule

// File: rtl/borrow_select_subtractor_seq.sv
// borrow_select_subtractor_seq: multi-cycle a - b - borrow_in, CHUNK bits per cycle.
// Define SUB_FLAGS_EN to add registered zero/ovf outputs.
module borrow_select_subtractor_seq
   import sub_pkg::*;
#(
   parameter int N     = 32,
   parameter int CHUNK = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         borrow_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] diff,
   output logic         borrow_out
`ifdef SUB_FLAGS_EN
   ,
   output logic         zero,
   output logic         ovf
`endif
);
   localparam int NC = N / CHUNK;
   localparam int IW = idx_w(NC);
   localparam logic [IW-1:0] LAST = IW'(NC - 1);

   if (CHUNK < 1 || CHUNK > N || (N % CHUNK) != 0) begin : g_bad_cfg
      $error("N must be a multiple of CHUNK with 1 <= CHUNK <= N");
   end

   sub_state_t    state_q, state_d;
   logic [N-1:0]  a_q, a_d, b_q, b_d, diff_q, diff_d;
   logic          bor_q, bor_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [CHUNK-1:0] a_k, b_k, d_k;
   logic          bo_k;
`ifdef SUB_FLAGS_EN
   logic          zero_q, zero_d, ovf_q, ovf_d;
`endif

   assign a_k = a_q[int'(idx_q) * CHUNK +: CHUNK];
   assign b_k = b_q[int'(idx_q) * CHUNK +: CHUNK];

   // The registered borrow selects between the slice's two precomputed results.
   sub_chunk #(.W(CHUNK)) u_chunk (
      .a    (a_k),
      .b    (b_k),
      .bin  (bor_q),
      .d    (d_k),
      .bout (bo_k)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      diff_d  = diff_q;
      bor_d   = bor_q;
      idx_d   = idx_q;
`ifdef SUB_FLAGS_EN
      zero_d  = zero_q;
      ovf_d   = ovf_q;
`endif
      if (state_q == IDLE) begin
         if (in_valid) begin
            a_d     = a;
            b_d     = b;
            bor_d   = borrow_in;
            idx_d   = '0;
            state_d = CALC;
`ifdef SUB_FLAGS_EN
            zero_d  = 1'b1;
`endif
         end
      end else if (state_q == CALC) begin
         diff_d[int'(idx_q) * CHUNK +: CHUNK] = d_k;
         bor_d   = bo_k;
         idx_d   = idx_q + 1'b1;
         state_d = (idx_q == LAST) ? DONE : CALC;
`ifdef SUB_FLAGS_EN
         zero_d  = zero_q & ~|d_k;
         ovf_d   = (idx_q == LAST) ? ((a_q[N-1] ^ b_q[N-1]) & (d_k[CHUNK-1] ^ a_q[N-1])) : ovf_q;
`endif
      end else begin
         state_d = out_ready ? IDLE : DONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         diff_q  <= '0;
         bor_q   <= 1'b0;
         idx_q   <= '0;
`ifdef SUB_FLAGS_EN
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         diff_q  <= diff_d;
         bor_q   <= bor_d;
         idx_q   <= idx_d;
`ifdef SUB_FLAGS_EN
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign diff       = diff_q;
   assign borrow_out = bor_q;
`ifdef SUB_FLAGS_EN
   assign zero       = zero_q;
   assign ovf        = ovf_q;
`endif
endmodule

// File: tb/tb_borrow_select_subtractor_seq.sv
// tb_borrow_select_subtractor_seq: scoreboard bench, directed N=8/CHUNK=4 plus random N=32/8 and N=16/16 streams.
module tb_borrow_select_subtractor_seq;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct {longint d; bit bo; bit z; bit ov;} exp_t;

   function automatic exp_t model(longint a, longint b, bit bin, int n);
      exp_t   r;
      longint full = a - b - longint'(bin);
      r.d  = full & ((longint'(1) << n) - 1);
      r.bo = full < 0;
      r.z  = r.d == 0;
      r.ov = (((a >> (n-1)) & 1) != ((b >> (n-1)) & 1)) && (((r.d >> (n-1)) & 1) != ((a >> (n-1)) & 1));
      return r;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   logic rst8 = 1'b1, rst_r = 1'b1;
   logic iv8 = 0, ir8, ov8, or8 = 0, bi8 = 0, bo8;
   logic [7:0] a8 = 0, b8 = 0, d8;
   logic iv32 = 0, ir32, ov32, or32 = 0, bi32 = 0, bo32;
   logic [31:0] a32 = 0, b32 = 0, d32;
   logic iv16 = 0, ir16, ov16, or16 = 0, bi16 = 0, bo16;
   logic [15:0] a16 = 0, b16 = 0, d16;
`ifdef SUB_FLAGS_EN
   logic z8, f8, z32, f32, z16, f16;
`endif

   borrow_select_subtractor_seq #(.N(8), .CHUNK(4)) u8 (
      .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .borrow_in(bi8),
      .out_valid(ov8), .out_ready(or8), .diff(d8), .borrow_out(bo8)
`ifdef SUB_FLAGS_EN
      , .zero(z8), .ovf(f8)
`endif
   );
   borrow_select_subtractor_seq #(.N(32), .CHUNK(8)) u32 (
      .clk(clk), .rst(rst_r), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .borrow_in(bi32),
      .out_valid(ov32), .out_ready(or32), .diff(d32), .borrow_out(bo32)
`ifdef SUB_FLAGS_EN
      , .zero(z32), .ovf(f32)
`endif
   );
   borrow_select_subtractor_seq #(.N(16), .CHUNK(16)) u16 (
      .clk(clk), .rst(rst_r), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .borrow_in(bi16),
      .out_valid(ov16), .out_ready(or16), .diff(d16), .borrow_out(bo16)
`ifdef SUB_FLAGS_EN
      , .zero(z16), .ovf(f16)
`endif
   );

   exp_t q8[$], q32[$], q16[$];
   exp_t e8, e32, e16;

   always @(negedge clk) begin
      if (rst8) q8.delete();
      else begin
         if (iv8 && ir8) q8.push_back(model(longint'(a8), longint'(b8), bi8, 8));
         if (ov8 && or8) begin
            if (q8.size() == 0) chk("n8 unexpected result", 1, 0);
            else begin
               e8 = q8.pop_front();
               chk("n8 scb diff", longint'(d8), e8.d);
               chk("n8 scb borrow", longint'(bo8), longint'(e8.bo));
`ifdef SUB_FLAGS_EN
               chk("n8 scb zero", longint'(z8), longint'(e8.z));
               chk("n8 scb ovf", longint'(f8), longint'(e8.ov));
`endif
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_r) begin
         q32.delete();
         q16.delete();
      end else begin
         if (iv32 && ir32) q32.push_back(model(longint'(a32), longint'(b32), bi32, 32));
         if (iv16 && ir16) q16.push_back(model(longint'(a16), longint'(b16), bi16, 16));
         if (ov32 && or32) begin
            if (q32.size() == 0) chk("n32 unexpected result", 1, 0);
            else begin
               e32 = q32.pop_front();
               chk("n32 scb diff", longint'(d32), e32.d);
               chk("n32 scb borrow", longint'(bo32), longint'(e32.bo));
`ifdef SUB_FLAGS_EN
               chk("n32 scb zero", longint'(z32), longint'(e32.z));
               chk("n32 scb ovf", longint'(f32), longint'(e32.ov));
`endif
            end
         end
         if (ov16 && or16) begin
            if (q16.size() == 0) chk("n16 unexpected result", 1, 0);
            else begin
               e16 = q16.pop_front();
               chk("n16 scb diff", longint'(d16), e16.d);
               chk("n16 scb borrow", longint'(bo16), longint'(e16.bo));
`ifdef SUB_FLAGS_EN
               chk("n16 scb zero", longint'(z16), longint'(e16.z));
               chk("n16 scb ovf", longint'(f16), longint'(e16.ov));
`endif
            end
         end
      end
   end

   // Directed op on the N=8/CHUNK=4 instance; latency counted with the accept cycle as cycle 0.
   task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] b, input bit bin,
                      input logic [7:0] ed, input bit eb, input bit ez, input bit eo, input int hold);
      int cyc;
      a8 = a; b8 = b; bi8 = bin; iv8 = 1; or8 = 0;
      chk({nm, " in_ready"}, longint'(ir8), 1);
      @(posedge clk); #1;
      iv8 = 0;
      cyc = 1;
      while (!ov8 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({nm, " latency"}, cyc, 3);
      chk({nm, " diff"}, longint'(d8), longint'(ed));
      chk({nm, " borrow"}, longint'(bo8), longint'(eb));
`ifdef SUB_FLAGS_EN
      chk({nm, " zero"}, longint'(z8), longint'(ez));
      chk({nm, " ovf"}, longint'(f8), longint'(eo));
`else
      if (ez || eo) cyc = cyc + 0;
`endif
      for (int i = 0; i < hold; i++) begin
         iv8 = 1; a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
         @(posedge clk); #1;
         chk({nm, " hold valid"}, longint'(ov8), 1);
         chk({nm, " hold in_ready"}, longint'(ir8), 0);
         chk({nm, " hold diff"}, longint'(d8), longint'(ed));
         chk({nm, " hold borrow"}, longint'(bo8), longint'(eb));
`ifdef SUB_FLAGS_EN
         chk({nm, " hold zero"}, longint'(z8), longint'(ez));
`endif
      end
      iv8 = 0; or8 = 1;
      @(posedge clk); #1;
      or8 = 0;
      chk({nm, " released valid"}, longint'(ov8), 0);
      chk({nm, " released in_ready"}, longint'(ir8), 1);
   endtask

   task automatic stream32();
      for (int i = 0; i < 1000; i++) begin
         int  bud = 0;
         bit  acc;
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         a32 = $urandom; b32 = ($urandom_range(0, 7) == 0) ? a32 : $urandom; bi32 = 1'($urandom);
         iv32 = 1;
         do begin
            acc = ir32;
            @(posedge clk); #1;
            bud++;
         end while (!acc && bud < 50);
         iv32 = 0;
         if (!acc) chk("n32 accept timeout", 0, 1);
      end
   endtask

   task automatic stream16();
      for (int i = 0; i < 1000; i++) begin
         int  bud = 0;
         bit  acc;
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         a16 = 16'($urandom); b16 = ($urandom_range(0, 7) == 0) ? a16 : 16'($urandom); bi16 = 1'($urandom);
         iv16 = 1;
         do begin
            acc = ir16;
            @(posedge clk); #1;
            bud++;
         end while (!acc && bud < 50);
         iv16 = 0;
         if (!acc) chk("n16 accept timeout", 0, 1);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         or32 = 1'($urandom);
         or16 = 1'($urandom);
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      repeat (3) @(posedge clk);
      #1;
      rst8 = 0; rst_r = 0;
      chk("reset in_ready", longint'(ir8), 1);
      chk("reset out_valid", longint'(ov8), 0);
      chk("reset diff", longint'(d8), 0);
      chk("reset borrow", longint'(bo8), 0);
`ifdef SUB_FLAGS_EN
      chk("reset zero", longint'(z8), 0);
      chk("reset ovf", longint'(f8), 0);
`endif
      fork
         begin
            op8("basic", 8'h5A, 8'h3C, 0, 8'h1E, 0, 0, 0, 0);
            op8("bin1", 8'h10, 8'h20, 1, 8'hEF, 1, 0, 0, 0);
            op8("xchunk", 8'h00, 8'h01, 0, 8'hFF, 1, 0, 0, 0);
            op8("ovf", 8'h80, 8'h01, 0, 8'h7F, 0, 0, 1, 0);
            op8("bp", 8'h33, 8'h33, 0, 8'h00, 0, 1, 0, 5);
            a8 = 8'h77; b8 = 8'h11; bi8 = 0; iv8 = 1;
            @(posedge clk); #1;
            iv8 = 0;
            @(posedge clk); #1;
            rst8 = 1;
            @(posedge clk); #1;
            rst8 = 0;
            chk("midrst in_ready", longint'(ir8), 1);
            chk("midrst out_valid", longint'(ov8), 0);
            chk("midrst diff", longint'(d8), 0);
            chk("midrst borrow", longint'(bo8), 0);
            op8("after rst", 8'h09, 8'h04, 0, 8'h05, 0, 0, 0, 0);
         end
         stream32();
         stream16();
      join
      w = 0;
      while ((q8.size() != 0 || q32.size() != 0 || q16.size() != 0) && w < 500) begin
         @(posedge clk); #1;
         w++;
      end
      chk("drain n8", q8.size(), 0);
      chk("drain n32", q32.size(), 0);
      chk("drain n16", q16.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
